// File: rtl/mac_window_scheduler.sv
// mac_window_scheduler
// Sequences a shared pixel multiplier across one KERNEL_SIZE x KERNEL_SIZE
// convolution window. It pairs each weight tap with one streamed feature pixel,
// issues each pair to the multiplier, accumulates the returned products, and
// emits one window sum.
// Ports:
//   i_clk, i_rst_n                 clock, async active-low reset
//   i_wgt_load/i_wgt_data          weight bank write (IDLE only)
//   o_wgt_loaded                   all TAPS weights present
//   i_start                        process one window
//   i_feat_valid/i_feat_data       feature stream, o_feat_ready handshake
//   o_mul_weight/o_mul_feature     multiplier operands
//   o_mul_enable_colw/_colip       multiplier enables
//   i_mul_product/i_mul_ready      multiplier result
//   o_sum/o_sum_valid              window sum, single-cycle pulse
//   o_busy                         high in ISSUE, DRAIN and DONE
module mac_window_scheduler #(
  parameter int unsigned BIT_WIDTH   = 8,
  parameter int unsigned KERNEL_SIZE = 3,
  parameter int unsigned ACC_WIDTH   = 20
) (
  input  logic                   i_clk,
  input  logic                   i_rst_n,
  input  logic                   i_wgt_load,
  input  logic [BIT_WIDTH-1:0]   i_wgt_data,
  output logic                   o_wgt_loaded,
  input  logic                   i_start,
  input  logic                   i_feat_valid,
  input  logic [BIT_WIDTH-1:0]   i_feat_data,
  output logic                   o_feat_ready,
  output logic [BIT_WIDTH-1:0]   o_mul_weight,
  output logic [BIT_WIDTH-1:0]   o_mul_feature,
  output logic                   o_mul_enable_colw,
  output logic                   o_mul_enable_colip,
  input  logic [2*BIT_WIDTH-1:0] i_mul_product,
  input  logic                   i_mul_ready,
  output logic [ACC_WIDTH-1:0]   o_sum,
  output logic                   o_sum_valid,
  output logic                   o_busy
);

  localparam int unsigned TAPS  = KERNEL_SIZE * KERNEL_SIZE;
  localparam int unsigned PTR_W = (TAPS > 1) ? $clog2(TAPS) : 1;
  localparam int unsigned CNT_W = $clog2(TAPS + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_e;

  state_e               state_q, state_d;
  logic [PTR_W-1:0]     wptr_q, wptr_d;
  logic [PTR_W-1:0]     tap_q, tap_d;
  logic [CNT_W-1:0]     pcnt_q, pcnt_d;
  logic [ACC_WIDTH-1:0] acc_q, acc_d;
  logic [ACC_WIDTH-1:0] sum_q, sum_d;
  logic                 sum_valid_q, sum_valid_d;
  logic                 loaded_q, loaded_d;
  logic [BIT_WIDTH-1:0] mw_q, mw_d;
  logic [BIT_WIDTH-1:0] mf_q, mf_d;
  logic                 en_q, en_d;
  logic [BIT_WIDTH-1:0] bank_q [TAPS];
  logic                 wr_en;
  logic                 hs;
  logic                 prod_take;

  // Next-state: weight loading in IDLE, issue/collect in ISSUE/DRAIN.
  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    tap_d       = tap_q;
    pcnt_d      = pcnt_q;
    acc_d       = acc_q;
    sum_d       = sum_q;
    sum_valid_d = 1'b0;
    loaded_d    = loaded_q;
    mw_d        = mw_q;
    mf_d        = mf_q;
    en_d        = 1'b0;
    wr_en       = 1'b0;
    hs          = 1'b0;
    prod_take   = 1'b0;
    case (state_q)
      IDLE: begin
        if (i_wgt_load) begin
          wr_en  = 1'b1;
          wptr_d = (wptr_q == PTR_W'(TAPS - 1)) ? '0 : wptr_q + PTR_W'(1);
          if (wptr_q == PTR_W'(TAPS - 1)) loaded_d = 1'b1;
        end
        if (i_start && loaded_q) begin
          state_d = ISSUE;
          acc_d   = '0;
          tap_d   = '0;
          pcnt_d  = '0;
        end
      end
      ISSUE, DRAIN: begin
        hs = (state_q == ISSUE) && i_feat_valid;
        if (hs) begin
          mw_d  = bank_q[tap_q];
          mf_d  = i_feat_data;
          en_d  = 1'b1;
          tap_d = (tap_q == PTR_W'(TAPS - 1)) ? '0 : tap_q + PTR_W'(1);
        end
        // Products beyond TAPS are stray and dropped.
        prod_take = i_mul_ready && (pcnt_q < CNT_W'(TAPS));
        if (prod_take) begin
          acc_d  = acc_q + ACC_WIDTH'(i_mul_product);
          pcnt_d = pcnt_q + CNT_W'(1);
        end
        // Completion by product count wins over the ISSUE->DRAIN step.
        if (pcnt_d == CNT_W'(TAPS)) begin
          state_d     = DONE;
          sum_d       = acc_d;
          sum_valid_d = 1'b1;
        end else if (hs && (tap_q == PTR_W'(TAPS - 1))) begin
          state_d = DRAIN;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and output registers.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= IDLE;
      wptr_q      <= '0;
      tap_q       <= '0;
      pcnt_q      <= '0;
      acc_q       <= '0;
      sum_q       <= '0;
      sum_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
      mw_q        <= '0;
      mf_q        <= '0;
      en_q        <= 1'b0;
      for (int i = 0; i < int'(TAPS); i++) bank_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      tap_q       <= tap_d;
      pcnt_q      <= pcnt_d;
      acc_q       <= acc_d;
      sum_q       <= sum_d;
      sum_valid_q <= sum_valid_d;
      loaded_q    <= loaded_d;
      mw_q        <= mw_d;
      mf_q        <= mf_d;
      en_q        <= en_d;
      if (wr_en) bank_q[wptr_q] <= i_wgt_data;
    end
  end

  assign o_wgt_loaded       = loaded_q;
  assign o_feat_ready       = (state_q == ISSUE);
  assign o_mul_weight       = mw_q;
  assign o_mul_feature      = mf_q;
  assign o_mul_enable_colw  = en_q;
  assign o_mul_enable_colip = en_q;
  assign o_sum              = sum_q;
  assign o_sum_valid        = sum_valid_q;
  assign o_busy             = (state_q != IDLE);

endmodule

// File: tb/tb_mac_window_scheduler.sv
// Directed bench for mac_window_scheduler with a 2-cycle multiplier model.
module tb_mac_window_scheduler;

  logic        clk;
  logic        rst_n;
  logic        i_wgt_load;
  logic [7:0]  i_wgt_data;
  logic        o_wgt_loaded;
  logic        i_start;
  logic        i_feat_valid;
  logic [7:0]  i_feat_data;
  logic        o_feat_ready;
  logic [7:0]  o_mul_weight;
  logic [7:0]  o_mul_feature;
  logic        o_mul_enable_colw;
  logic        o_mul_enable_colip;
  logic [15:0] i_mul_product;
  logic        i_mul_ready;
  logic [19:0] o_sum;
  logic        o_sum_valid;
  logic        o_busy;

  int tests = 0;
  int fails = 0;

  mac_window_scheduler dut (
    .i_clk              (clk),
    .i_rst_n            (rst_n),
    .i_wgt_load         (i_wgt_load),
    .i_wgt_data         (i_wgt_data),
    .o_wgt_loaded       (o_wgt_loaded),
    .i_start            (i_start),
    .i_feat_valid       (i_feat_valid),
    .i_feat_data        (i_feat_data),
    .o_feat_ready       (o_feat_ready),
    .o_mul_weight       (o_mul_weight),
    .o_mul_feature      (o_mul_feature),
    .o_mul_enable_colw  (o_mul_enable_colw),
    .o_mul_enable_colip (o_mul_enable_colip),
    .i_mul_product      (i_mul_product),
    .i_mul_ready        (i_mul_ready),
    .o_sum              (o_sum),
    .o_sum_valid        (o_sum_valid),
    .o_busy             (o_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Two-stage multiplier: product appears two cycles after the enable.
  logic        p1_v, p2_v;
  logic [15:0] p1, p2;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p1_v <= 1'b0; p2_v <= 1'b0; p1 <= '0; p2 <= '0;
    end else begin
      p1_v <= o_mul_enable_colw & o_mul_enable_colip;
      p1   <= 16'(o_mul_weight) * 16'(o_mul_feature);
      p2_v <= p1_v;
      p2   <= p1;
    end
  end
  assign i_mul_ready   = p2_v;
  assign i_mul_product = p2;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load(input logic [7:0] v);
    i_wgt_load = 1'b1;
    i_wgt_data = v;
    step();
    i_wgt_load = 1'b0;
  endtask

  // Runs one window; counts ready cycles, enable pulses and sum pulses.
  task automatic run_window(input logic [7:0] feat, input bit toggle, input bit wload,
                            output int rdy, output int en, output int pulses,
                            output logic [19:0] sum, output logic busy_after,
                            output bit hold_ok);
    logic [7:0] pw, pf;
    bit seen;
    int after;
    rdy = 0; en = 0; pulses = 0; sum = '0; busy_after = 1'b1; hold_ok = 1'b1;
    seen = 1'b0; after = -1; pw = '0; pf = '0;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    for (int k = 0; k < 60 && after != 0; k++) begin
      if (o_feat_ready) rdy++;
      if (o_mul_enable_colw) begin
        en++;
        seen = 1'b1;
      end else if (seen && (o_mul_weight !== pw || o_mul_feature !== pf)) begin
        hold_ok = 1'b0;
      end
      pw = o_mul_weight;
      pf = o_mul_feature;
      if (o_sum_valid) begin
        pulses++;
        sum = o_sum;
        if (after < 0) after = 3;
      end
      i_feat_valid = toggle ? (k % 2 == 0) : 1'b1;
      i_feat_data  = i_feat_valid ? feat : 8'hAA;
      i_wgt_load   = wload && (k < 3);
      i_wgt_data   = 8'd7;
      step();
      if (after == 3) busy_after = o_busy;
      if (after > 0) after--;
    end
    i_feat_valid = 1'b0;
    i_wgt_load   = 1'b0;
  endtask

  int          rdy, en, pulses, cnt, busy_seen;
  logic [19:0] sum;
  logic        busy_after;
  bit          hold_ok;

  initial begin
    rst_n = 1'b0; i_wgt_load = 1'b0; i_wgt_data = '0; i_start = 1'b0;
    i_feat_valid = 1'b0; i_feat_data = '0;
    step(); step();
    check("rst_busy",   32'(o_busy), 0);
    check("rst_loaded", 32'(o_wgt_loaded), 0);
    check("rst_sum",    32'(o_sum), 0);
    check("rst_sumv",   32'(o_sum_valid), 0);
    check("rst_ready",  32'(o_feat_ready), 0);
    check("rst_en",     32'(o_mul_enable_colw), 0);
    rst_n = 1'b1;
    step();

    // Start without weights, then with a partial bank.
    i_start = 1'b1; step(); i_start = 1'b0;
    check("start_noweights_busy", 32'(o_busy), 0);
    for (int i = 1; i <= 5; i++) load(8'(i));
    check("loaded_after5", 32'(o_wgt_loaded), 0);
    i_start = 1'b1; step(); i_start = 1'b0;
    check("start_5loads_busy", 32'(o_busy), 0);
    for (int i = 6; i <= 8; i++) load(8'(i));
    check("loaded_after8", 32'(o_wgt_loaded), 0);
    load(8'd9);
    check("loaded_after9", 32'(o_wgt_loaded), 1);

    // Weights 1..9, features 2 held valid: 2*45 = 90.
    run_window(8'd2, 1'b0, 1'b0, rdy, en, pulses, sum, busy_after, hold_ok);
    check("w1_ready_cycles", 32'(rdy), 9);
    check("w1_enables",      32'(en), 9);
    check("w1_pulses",       32'(pulses), 1);
    check("w1_sum",          32'(sum), 90);
    check("w1_busy_after",   32'(busy_after), 0);

    // Toggling valid with junk data in the gaps.
    run_window(8'd2, 1'b1, 1'b0, rdy, en, pulses, sum, busy_after, hold_ok);
    check("tog_enables", 32'(en), 9);
    check("tog_pulses",  32'(pulses), 1);
    check("tog_sum",     32'(sum), 90);
    check("tog_hold",    32'(hold_ok), 1);

    // Weight writes during ISSUE must be ignored.
    run_window(8'd2, 1'b0, 1'b1, rdy, en, pulses, sum, busy_after, hold_ok);
    check("wl_busy_sum", 32'(sum), 90);
    run_window(8'd2, 1'b0, 1'b0, rdy, en, pulses, sum, busy_after, hold_ok);
    check("wl_next_sum", 32'(sum), 90);

    // All-255 window: 9*255*255 = 585225; reload must wrap onto taps 0..8.
    for (int i = 0; i < 9; i++) load(8'd255);
    check("loaded_stays", 32'(o_wgt_loaded), 1);
    run_window(8'd255, 1'b0, 1'b0, rdy, en, pulses, sum, busy_after, hold_ok);
    check("max_sum",    32'(sum), 585225);
    check("max_pulses", 32'(pulses), 1);

    // Reset after 4 issued taps.
    i_start = 1'b1; step(); i_start = 1'b0;
    i_feat_valid = 1'b1; i_feat_data = 8'd3;
    cnt = 0;
    for (int k = 0; k < 20 && cnt < 4; k++) begin
      step();
      if (o_mul_enable_colw) cnt++;
    end
    check("mid_taps", 32'(cnt), 4);
    rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   32'(o_busy), 0);
    check("mid_rst_ready",  32'(o_feat_ready), 0);
    check("mid_rst_en",     32'(o_mul_enable_colw | o_mul_enable_colip), 0);
    check("mid_rst_w",      32'(o_mul_weight), 0);
    check("mid_rst_f",      32'(o_mul_feature), 0);
    check("mid_rst_sum",    32'(o_sum), 0);
    check("mid_rst_loaded", 32'(o_wgt_loaded), 0);
    #2;
    rst_n = 1'b1;
    i_feat_valid = 1'b0;
    step();
    i_start = 1'b1; step(); i_start = 1'b0;
    busy_seen = 0;
    for (int k = 0; k < 6; k++) begin
      if (o_busy || o_sum_valid) busy_seen++;
      step();
    end
    check("post_rst_start_ignored", 32'(busy_seen), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
